// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state codes,
// parity type selectors and serial line levels.
package uart_tx_pkg;

  // One-hot state codes
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  typedef enum logic [4:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  // Parity type selectors
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake of the UART transmitter: byte, strobe, parity
// configuration, plus the serial line and busy flag coming back.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  // Upstream data source side
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  // Transmitter side
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity generator shared by the UART TX and RX paths.
// Even parity is the XOR of the data; odd parity is its complement.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             par_bit_o
);

  logic xor_s;

  // Reduce the data word and apply the parity type
  always_comb begin
    xor_s = ^data_i;
    if (par_typ_i == PAR_ODD) begin
      par_bit_o = ~xor_s;
    end else begin
      par_bit_o = xor_s;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a one-cycle strobe and sends
// start, data (LSB first), optional parity and stop bits, one bit per
// CLK cycle. TX_OUT and Busy are registered; the register holds the
// level for the state being entered, so the line changes on the edge.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic   CLK,
  input  logic   RST,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit_s;

  // Parity of the incoming byte; captured only when the byte is accepted
  uart_tx_parity #(
    .WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i   (bus.P_DATA),
    .par_typ_i(bus.PAR_TYP),
    .par_bit_o(par_bit_s)
  );

  // State, datapath and output registers; reset forces an idle-high line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // Next state, shift/count updates and the line level of the next state
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = LINE_IDLE;

    case (state_q)
      IDLE, STOP: begin
        // Stop cycle accepts too, giving gap-free back-to-back frames
        if (bus.DATA_VALID) begin
          data_d   = bus.P_DATA;
          par_en_d = bus.PAR_EN;
          par_d    = par_bit_s;
          state_d  = START;
          tx_d     = START_BIT;
        end else begin
          state_d  = IDLE;
          tx_d     = LINE_IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
        data_d  = {1'b0, data_q[DATA_WIDTH-1:1]};
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          // Next data bit sits in the LSB after the previous shift
          state_d = DATA;
          tx_d    = data_q[0];
          data_d  = {1'b0, data_q[DATA_WIDTH-1:1]};
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level queue model checked
// every cycle, plus directed frames compared against literal bit lists.
module tb_uart_tx;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Model: queue of line levels still to appear, one entry per cycle.
  logic exp_q[$];
  logic acc_m;
  logic exp_tx_m;
  logic exp_busy_m;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
    end else begin
      // A byte is taken when the line is idle or showing its last (stop) bit
      acc_m = bus.DATA_VALID && (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc_m) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(bus.P_DATA[i]);
        if (bus.PAR_EN) exp_q.push_back(bus.PAR_TYP ? ~(^bus.P_DATA) : (^bus.P_DATA));
        exp_q.push_back(1'b1);
      end
    end
    #1;
    exp_tx_m   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
    exp_busy_m = (exp_q.size() > 0);
    chk("model_tx", 32'(bus.TX_OUT), 32'(exp_tx_m));
    chk("model_busy", 32'(bus.Busy), 32'(exp_busy_m));
  end

  // Present a byte for one cycle; starts and ends on a falling edge
  task automatic pulse(input logic [7:0] d, input logic pen, input logic ptyp);
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
  endtask

  // Record n line samples (one per cycle) and count Busy-high cycles
  task automatic capture(input int n, output logic [15:0] line, output int bc);
    line = '0;
    bc   = 0;
    for (int i = 0; i < n; i++) begin
      line[i] = bus.TX_OUT;
      bc += int'(bus.Busy);
      @(negedge CLK);
    end
  endtask

  logic [15:0] line;
  logic [15:0] line2;
  int          bc;
  int          bc2;

  initial begin
    checks         = 0;
    failures       = 0;
    RST            = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset_tx", 32'(bus.TX_OUT), 32'd1);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_tx", 32'(bus.TX_OUT), 32'd1);

    // Even parity, 8'hA5
    pulse(8'hA5, 1'b1, 1'b0);
    capture(12, line, bc);
    chk("even_a5_line", 32'(line[10:0]), 32'(11'b10101001010));
    chk("even_a5_par", 32'(line[9]), 32'd0);
    chk("even_a5_busy", 32'(bc), 32'd11);
    chk("even_a5_idle", 32'(line[11]), 32'd1);

    // Odd parity, 8'h01 and 8'h03
    pulse(8'h01, 1'b1, 1'b1);
    capture(12, line, bc);
    chk("odd_01_line", 32'(line[10:0]), 32'(11'b10000000010));
    chk("odd_01_par", 32'(line[9]), 32'd0);
    chk("odd_01_busy", 32'(bc), 32'd11);
    pulse(8'h03, 1'b1, 1'b1);
    capture(12, line, bc);
    chk("odd_03_line", 32'(line[10:0]), 32'(11'b11000000110));
    chk("odd_03_par", 32'(line[9]), 32'd1);

    // No parity, 8'hFF
    pulse(8'hFF, 1'b0, 1'b0);
    capture(11, line, bc);
    chk("nopar_ff_line", 32'(line[9:0]), 32'(10'b1111111110));
    chk("nopar_ff_busy", 32'(bc), 32'd10);
    chk("nopar_ff_idle", 32'(line[10]), 32'd1);

    // Back-to-back: 8'h55 then 8'h0F, strobe in the stop cycle
    pulse(8'h55, 1'b0, 1'b0);
    capture(9, line, bc);
    chk("b2b_first_line", 32'(line[8:0]), 32'(9'b010101010));
    chk("b2b_first_busy", 32'(bc), 32'd9);
    chk("b2b_stop_tx", 32'(bus.TX_OUT), 32'd1);
    chk("b2b_stop_busy", 32'(bus.Busy), 32'd1);
    pulse(8'h0F, 1'b0, 1'b0);
    capture(11, line2, bc2);
    chk("b2b_second_line", 32'(line2[9:0]), 32'(10'b1000011110));
    chk("b2b_second_busy", 32'(bc2), 32'd10);

    // Strobe during DATA is dropped; config changes mid-frame are ignored
    pulse(8'hC3, 1'b1, 1'b0);
    line = '0;
    for (int i = 0; i < 12; i++) begin
      line[i] = bus.TX_OUT;
      if (i == 3) begin
        bus.P_DATA     = 8'h33;
        bus.PAR_TYP    = 1'b1;
        bus.PAR_EN     = 1'b0;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 4) bus.DATA_VALID = 1'b0;
      @(negedge CLK);
    end
    chk("drop_c3_line", 32'(line[11:0]), 32'(12'b110110000110));
    capture(3, line, bc);
    chk("drop_idle_line", 32'(line[2:0]), 32'(3'b111));
    chk("drop_idle_busy", 32'(bc), 32'd0);
    bus.PAR_TYP = 1'b0;

    // Asynchronous reset in the middle of the data bits
    pulse(8'hA5, 1'b1, 1'b0);
    capture(4, line, bc);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_tx", 32'(bus.TX_OUT), 32'd1);
    chk("async_rst_busy", 32'(bus.Busy), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    capture(3, line, bc);
    chk("post_rst_line", 32'(line[2:0]), 32'(3'b111));
    chk("post_rst_busy", 32'(bc), 32'd0);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART block, the outgoing counterpart of the UART receive path. It accepts a parallel byte with a one-cycle valid strobe and serialises it onto `TX_OUT` as one UART frame:
- start bit;
- data bits, LSB first;
- optional even/odd parity bit;
- one stop bit.

It runs on the TX baud-rate clock, so each bit lasts exactly one `CLK` cycle. `Busy` tells the upstream data source when a new byte can be presented.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame.
- `CLK` in 1: TX baud clock, one bit period per cycle.
- `RST` in 1: reset, asynchronous, active-low.
- `P_DATA` in `DATA_WIDTH`: parallel byte to send.
- `DATA_VALID` in 1: one-cycle strobe; `P_DATA` is valid in this cycle.
- `PAR_EN` in 1: 1 inserts a parity bit.
- `PAR_TYP` in 1: 0 = even parity, 1 = odd parity.
- `TX_OUT` out 1: serial line. Registered. Idles high.
- `Busy` out 1: high while a frame is on the line. Registered.

## Operation
- States, one-hot: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `TX_OUT`=1, `Busy`=0.
  - If `DATA_VALID`=1, the block accepts the byte at this edge:
    - latch `P_DATA` into the shift register;
    - latch `PAR_EN` and `PAR_TYP`;
    - compute the parity bit from the latched data: even = ^data, odd = ~^data;
    - go to START.
- **START:** drive `TX_OUT`=0, then go to DATA with the bit counter at 0.
- **DATA:** drive `TX_OUT` = data[bit_cnt].
  - Increment `bit_cnt`, width $clog2(`DATA_WIDTH`).
  - At `bit_cnt` = `DATA_WIDTH`-1, go to PARITY if the latched `PAR_EN`=1, else to STOP.
- **PARITY:** drive `TX_OUT` = latched parity bit, then go to STOP.
- **STOP:** drive `TX_OUT`=1.
  - If `DATA_VALID`=1 in this cycle, accept the new byte as in IDLE and go straight to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- **`Busy`:** 1 in START, DATA, PARITY and STOP.
- **`DATA_VALID` while busy:** ignored and the byte is dropped if asserted while `Busy`=1 in any state other than STOP. Avoiding this is the upstream's responsibility.
- **Mid-frame input changes:** changes on `P_DATA`, `PAR_EN` or `PAR_TYP` have no effect on the frame in flight; only the latched copies are used.
- **Reset:** on `RST` low, at any point including mid-frame:
  - state goes to IDLE;
  - `TX_OUT`=1 and `Busy`=0 immediately (asynchronous);
  - shift register, bit counter and parity bit are cleared.
- **Illegal or unreachable state code:** return to IDLE on the next edge with `TX_OUT`=1.

## Timing
- Edge k samples `DATA_VALID`=1 in IDLE.
- Cycle k+1: start bit, `TX_OUT`=0, `Busy`=1.
- Cycles k+2 .. k+1+`DATA_WIDTH`: data bits d0 .. d7.
- Cycle k+10: parity bit, if enabled.
- Stop bit: cycle k+11 with parity, k+10 without.
- Frame length: 11 cycles with parity, 10 without.
- After the stop bit, with no new `DATA_VALID`: `Busy` falls and `TX_OUT` stays 1.
- Back-to-back: `DATA_VALID` in the stop cycle produces the next start bit in the following cycle, and `Busy` stays 1 throughout.
- All outputs change only on `CLK` rising edge, except under asynchronous reset.

## Structure
- Shared package holds:
  - state one-hot localparams (IDLE, START, DATA, PARITY, STOP);
  - `PAR_EVEN`=0, `PAR_ODD`=1;
  - line-level constants `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1.
- One natural sub-module: `uart_tx_parity`.
  - Combinational parity of the data and `PAR_TYP`.
  - Output registered in the top at accept.
  - Reused by the receive path's parity checker.
- Top level holds the FSM, shift register/bit counter and output mux register.

## Test plan
- **Reset:** `RST` low mid-DATA → `TX_OUT`=1 and `Busy`=0 immediately; after release, IDLE with a stable high line.
- **Even parity:** `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0 → line reads 0,1,0,1,0,0,1,0,1,0,1. The parity bit is 0.
- **Odd parity:** `P_DATA`=8'h01, `PAR_EN`=1, `PAR_TYP`=1 → parity bit 0, 11-cycle frame. With `P_DATA`=8'h03 the parity bit is 1.
- **No parity:** `P_DATA`=8'hFF, `PAR_EN`=0 → 10-cycle frame, 0 then nine 1s, and `Busy` high for exactly 10 cycles.
- **Back-to-back:** 8'h55 then 8'h0F with `DATA_VALID` pulsed in the stop cycle → start bit of the second frame immediately follows the stop bit, and `Busy` never drops.
- **Dropped strobe and latched config:** `DATA_VALID` during DATA with 8'h33, while `PAR_TYP` toggles mid-frame → current frame unchanged, 8'h33 never transmitted, parity bit matches the latched `PAR_TYP`.
